// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv_host memory responder.
package conv_pkg;
   localparam logic [2:0]  CSEL_L0   = 3'b001;
   localparam logic [2:0]  CSEL_L1   = 3'b011;
   localparam int unsigned IMG_WORDS = 4096;
   localparam int unsigned L1_WORDS  = 1024;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_ARM,
      ST_RUN,
      ST_DRAIN
   } host_st_t;
endpackage

// File: rtl/conv_layer_ram.sv
// Single-port-write RAM with an asynchronous read port; contents are never reset.
module conv_layer_ram #(
   parameter int DW = 20,
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/conv_host.sv
// Host-side image/layer memory responder for the conv engine.
// Optional drain stream of L0/L1 is built when CONV_HOST_DRAIN_EN is defined.
module conv_host
   import conv_pkg::*;
#(
   parameter int DW     = 20,
   parameter int IMG_AW = 12,
   parameter int L1_AW  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     s_data,
   output logic              ready,
   input  logic              busy,
   input  logic [IMG_AW-1:0] iaddr,
   output logic [DW-1:0]     idata,
   input  logic              cwr,
   input  logic [IMG_AW-1:0] caddr_wr,
   input  logic [DW-1:0]     cdata_wr,
   input  logic              crd,
   input  logic [IMG_AW-1:0] caddr_rd,
   output logic [DW-1:0]     cdata_rd,
   input  logic [2:0]        csel,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DW-1:0]     m_data,
   output logic              m_sel,
   output logic              m_last,
   output logic              done,
   output logic              err
);
   host_st_t          state;
   logic [IMG_AW-1:0] pcnt;
   logic              csel_l0, csel_l1, cmd_bad;
   logic              img_we, l0_we, l1_we;
   logic [IMG_AW-1:0] l0_raddr;
   logic [L1_AW-1:0]  l1_raddr;
   logic [DW-1:0]     l0_rdata, l1_rdata;

   assign csel_l0 = (csel == CSEL_L0);
   assign csel_l1 = (csel == CSEL_L1);
   assign img_we  = (state == ST_LOAD) && s_valid && s_ready;
   assign l0_we   = (state == ST_RUN) && cwr && csel_l0;
   assign l1_we   = (state == ST_RUN) && cwr && csel_l1;

   assign cmd_bad = ((cwr || crd) && !csel_l0 && !csel_l1)
                  || (cwr && (state != ST_RUN))
                  || (cwr && csel_l1 && (caddr_wr[IMG_AW-1:L1_AW] != '0));

   always_comb begin
      cdata_rd = '0;
      if (crd) begin
         if (csel_l0)      cdata_rd = l0_rdata;
         else if (csel_l1) cdata_rd = l1_rdata;
      end
   end

   conv_layer_ram #(.DW(DW), .AW(IMG_AW)) u_img (
      .clk(clk), .we(img_we), .waddr(pcnt), .wdata(s_data),
      .raddr(iaddr), .rdata(idata)
   );
   conv_layer_ram #(.DW(DW), .AW(IMG_AW)) u_l0 (
      .clk(clk), .we(l0_we), .waddr(caddr_wr), .wdata(cdata_wr),
      .raddr(l0_raddr), .rdata(l0_rdata)
   );
   conv_layer_ram #(.DW(DW), .AW(L1_AW)) u_l1 (
      .clk(clk), .we(l1_we), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
      .raddr(l1_raddr), .rdata(l1_rdata)
   );

`ifdef CONV_HOST_DRAIN_EN
   localparam int unsigned   DRAIN_LAST = (1 << IMG_AW) + (1 << L1_AW) - 1;
   localparam logic [IMG_AW:0] DLAST    = DRAIN_LAST[IMG_AW:0];
   logic [IMG_AW:0] dcnt;

   // Engine is idle while draining, so the layer read ports are borrowed for dcnt.
   assign l0_raddr = (state == ST_DRAIN) ? dcnt[IMG_AW-1:0] : caddr_rd;
   assign l1_raddr = (state == ST_DRAIN) ? dcnt[L1_AW-1:0]  : caddr_rd[L1_AW-1:0];
`else
   logic unused_m_ready;
   assign unused_m_ready = m_ready;
   assign l0_raddr = caddr_rd;
   assign l1_raddr = caddr_rd[L1_AW-1:0];
   assign m_valid  = 1'b0;
   assign m_data   = '0;
   assign m_sel    = 1'b0;
   assign m_last   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_LOAD;
         pcnt    <= '0;
         s_ready <= 1'b0;
         ready   <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
`ifdef CONV_HOST_DRAIN_EN
         dcnt    <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sel   <= 1'b0;
         m_last  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (cmd_bad) err <= 1'b1;
         case (state)
            ST_LOAD: begin
               s_ready <= 1'b1;
               if (img_we) begin
                  if (pcnt == '1) begin
                     state   <= ST_ARM;
                     pcnt    <= '0;
                     s_ready <= 1'b0;
                     ready   <= 1'b1;
                  end else begin
                     pcnt <= pcnt + 1'b1;
                  end
               end
            end
            ST_ARM: begin
               if (busy) begin
                  ready <= 1'b0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!busy) begin
`ifdef CONV_HOST_DRAIN_EN
                  state <= ST_DRAIN;
                  dcnt  <= '0;
`else
                  state   <= ST_LOAD;
                  s_ready <= 1'b1;
                  done    <= 1'b1;
`endif
               end
            end
`ifdef CONV_HOST_DRAIN_EN
            ST_DRAIN: begin
               if (!m_valid || m_ready) begin
                  if (m_valid && m_last) begin
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                     m_sel   <= 1'b0;
                     m_data  <= '0;
                     dcnt    <= '0;
                     done    <= 1'b1;
                     s_ready <= 1'b1;
                     state   <= ST_LOAD;
                  end else begin
                     m_valid <= 1'b1;
                     m_data  <= dcnt[IMG_AW] ? l1_rdata : l0_rdata;
                     m_sel   <= dcnt[IMG_AW];
                     m_last  <= (dcnt == DLAST);
                     dcnt    <= dcnt + 1'b1;
                  end
               end
            end
`endif
            default: state <= ST_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_host.sv
// Scoreboard bench for conv_host: load, handshake, layer paths, errors, drain, reset.
module tb_conv_host;
   import conv_pkg::*;

   localparam int DW     = 20;
   localparam int IMG_AW = 12;
   localparam int L1_AW  = 10;

   typedef struct packed {
      logic          sel;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              s_valid = 1'b0, s_ready;
   logic [DW-1:0]     s_data = '0;
   logic              ready, busy = 1'b0;
   logic [IMG_AW-1:0] iaddr = '0, caddr_wr = '0, caddr_rd = '0;
   logic [DW-1:0]     idata, cdata_wr = '0, cdata_rd;
   logic              cwr = 1'b0, crd = 1'b0;
   logic [2:0]        csel = 3'b000;
   logic              m_valid, m_ready = 1'b1, m_sel, m_last, done, err;
   logic [DW-1:0]     m_data;

   int n_cmp = 0, n_bad = 0, beats = 0, done_cnt = 0;
   logic [DW-1:0] rd_q[$];
   beat_t         drain_q[$];
   logic [DW-1:0] m_l0 [0:4095];
   logic [DW-1:0] m_l1 [0:1023];
   logic          pv = 1'b0, pr = 1'b0;
   logic [DW-1:0] pd = '0;

   conv_host #(.DW(DW), .IMG_AW(IMG_AW), .L1_AW(L1_AW)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .ready(ready), .busy(busy),
      .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_sel(m_sel), .m_last(m_last), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] sel, input int a, input logic [DW-1:0] d);
      csel = sel; caddr_wr = IMG_AW'(a); cdata_wr = d; cwr = 1'b1;
      cyc();
      cwr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] sel, input int a, input logic [DW-1:0] e);
      csel = sel; caddr_rd = IMG_AW'(a); crd = 1'b1;
      rd_q.push_back(e);
      cyc();
      crd = 1'b0;
   endtask

   // Monitor: pops expected read data and drain beats whenever the DUT presents them.
   always @(negedge clk) begin
      if (reset) begin
         if (done) done_cnt++;
         if (crd) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else chk("cdata_rd", 32'(cdata_rd), 32'(rd_q.pop_front()));
         end
         if (pv && !pr) chk("m_hold", {11'd0, m_valid, m_data}, {11'd0, 1'b1, pd});
         if (m_valid && m_ready) begin
            beats++;
            if (drain_q.size() == 0) chk("drain_extra", 32'(beats), 32'd0);
            else chk($sformatf("drain_beat%0d", beats - 1),
                     32'({m_sel, m_last, m_data}), 32'(drain_q.pop_front()));
         end
         pv = m_valid; pr = m_ready; pd = m_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b0;
      #2;
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_ready",   32'(ready),   0);
      chk("rst_m",       32'({m_valid, m_sel, m_last, m_data}), 0);
      chk("rst_done",    32'(done),    0);
      chk("rst_err",     32'(err),     0);
      cyc();
      reset = 1'b1;
      chk("s_ready_held", 32'(s_ready), 0);
      cyc();
      chk("s_ready_rise", 32'(s_ready), 1);

      // Load image with value = address
      s_valid = 1'b1;
      for (int a = 0; a < 4096; a++) begin
         s_data = DW'(a);
         cyc();
      end
      s_valid = 1'b0;
      chk("ready_after_load", 32'(ready), 1);
      chk("s_ready_after_load", 32'(s_ready), 0);
      iaddr = 12'd65; #1 chk("idata65", 32'(idata), 65);
      iaddr = 12'd4095; #1 chk("idata4095", 32'(idata), 4095);

      // s_valid in ARM is ignored and harmless
      s_valid = 1'b1; s_data = 20'd999;
      cyc();
      s_valid = 1'b0;
      cyc();
      iaddr = 12'd0; #1 chk("idata0_kept", 32'(idata), 0);
      chk("err_arm_svalid", 32'(err), 0);
      busy = 1'b1;
      chk("ready_before_edge", 32'(ready), 1);
      cyc();
      chk("ready_fall", 32'(ready), 0);

      for (int a = 0; a < 4096; a++) begin
         m_l0[a] = 20'hA0000 | DW'(a);
         wr(CSEL_L0, a, m_l0[a]);
      end
      for (int a = 0; a < 1024; a++) begin
         m_l1[a] = 20'h50000 | DW'(a);
         wr(CSEL_L1, a, m_l1[a]);
      end

      m_l0[100] = 20'h12345;
      wr(CSEL_L0, 100, 20'h12345);
      rd(CSEL_L0, 100, 20'h12345);
      rd(CSEL_L1, 100, m_l1[100]);

      m_l1[5] = 20'd7;
      wr(CSEL_L1, 5, 20'd7);
      csel = CSEL_L1; caddr_wr = 12'd5; caddr_rd = 12'd5; cdata_wr = 20'd9;
      cwr = 1'b1; crd = 1'b1;
      rd_q.push_back(20'd7);
      cyc();
      cwr = 1'b0; crd = 1'b0;
      m_l1[5] = 20'd9;
      rd(CSEL_L1, 5, 20'd9);
      chk("err_clean", 32'(err), 0);

      wr(3'b010, 100, 20'hFFFFF);
      chk("err_illegal", 32'(err), 1);
      rd(CSEL_L0, 100, 20'h12345);
      rd(CSEL_L1, 100, m_l1[100]);
      rd(3'b010, 100, 20'd0);
      chk("rd_q_empty", 32'(rd_q.size()), 0);

`ifdef CONV_HOST_DRAIN_EN
      for (int a = 0; a < 4096; a++) drain_q.push_back({1'b0, 1'b0, m_l0[a]});
      for (int a = 0; a < 1024; a++) drain_q.push_back({1'b1, (a == 1023), m_l1[a]});
      m_ready = 1'b0;
      busy = 1'b0;
      cyc();
      chk("m_valid_enter", 32'(m_valid), 0);
      cyc();
      chk("m_valid_rise", 32'(m_valid), 1);
      for (int i = 0; i < 20000; i++) begin
         m_ready = ~m_ready;
         cyc();
         if (done_cnt > 0 && drain_q.size() == 0) break;
      end
      chk("drain_done_seen", 32'(done_cnt > 0), 1);
      chk("s_ready_return", 32'(s_ready), 1);
      m_ready = 1'b1;
      repeat (3) cyc();
      chk("drain_beats", 32'(beats), 5120);
      chk("drain_q_empty", 32'(drain_q.size()), 0);
      chk("done_once", 32'(done_cnt), 1);
`else
      busy = 1'b0;
      cyc();
      chk("done_pulse", 32'(done), 1);
      chk("s_ready_return", 32'(s_ready), 1);
      chk("m_valid_tied", 32'(m_valid), 0);
      cyc();
      chk("done_once", 32'(done), 0);
      chk("no_beats", 32'(beats), 0);
`endif

      // Partial load, then reset mid-operation
      s_valid = 1'b1;
      for (int a = 0; a < 10; a++) begin
         s_data = DW'(1000 + a);
         cyc();
      end
      s_valid = 1'b0;
      reset = 1'b0;
      #2;
      chk("midrst_s_ready", 32'(s_ready), 0);
      chk("midrst_err", 32'(err), 0);
      cyc();
      reset = 1'b1;
      iaddr = 12'd3;  #1 chk("persist3", 32'(idata), 1003);
      iaddr = 12'd20; #1 chk("persist20", 32'(idata), 20);
      cyc();
      chk("midrst_s_ready_rise", 32'(s_ready), 1);
      s_valid = 1'b1; s_data = 20'd777;
      cyc();
      s_valid = 1'b0;
      iaddr = 12'd0; #1 chk("pcnt_restart", 32'(idata), 777);
      iaddr = 12'd1; #1 chk("pcnt_next_untouched", 32'(idata), 1001);
      wr(CSEL_L0, 7, 20'd1);
      chk("err_cwr_load", 32'(err), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
